// File: rtl/fifo_adapt_pkg.sv
// Shared types and constants for the FIFO read-port to stream adapter.
// Optional statistics counter is enabled with FIFO_RD_ADAPT_STATS_EN.
package fifo_adapt_pkg;

  // Occupancy is tracked in two bits; the buffer never holds more than two words.
  localparam int OCC_W      = 2;
  localparam int BEAT_CNT_W = 16;

  // Occupancy value at which the output buffer is full.
  localparam logic [OCC_W-1:0] OCC_FULL = 2'd2;

  // Encoded so the state value doubles as the occupancy count.
  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage : fifo_adapt_pkg

// File: rtl/fifo_rd_adapt_buf.sv
// Two-entry shift buffer feeding the stream output. Entry 0 is always the head;
// a pop from a full buffer shifts entry 1 down, and a simultaneous push lands in
// the slot freed by that shift. Vacated slots are cleared so the head reads zero
// whenever the buffer is empty.
module fifo_rd_adapt_buf
  import fifo_adapt_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [OCC_W-1:0]      occ_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  occ_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;

  // State and storage registers; reset discards everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OCC_EMPTY;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      state_q  <= state_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  // Next occupancy and entry contents from the push/pop pair.
  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    case (state_q)
      OCC_EMPTY: begin
        if (push_i) begin
          entry0_d = push_data_i;
          state_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push_i && pop_i) begin
          entry0_d = push_data_i;
        end else if (push_i) begin
          entry1_d = push_data_i;
          state_d  = OCC_TWO;
        end else if (pop_i) begin
          entry0_d = '0;
          state_d  = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop_i) begin
          entry0_d = entry1_q;
          if (push_i) begin
            entry1_d = push_data_i;
          end else begin
            entry1_d = '0;
            state_d  = OCC_ONE;
          end
        end
      end
      default: begin
        state_d  = OCC_EMPTY;
        entry0_d = '0;
        entry1_d = '0;
      end
    endcase
  end

  assign occ_o   = state_q;
  assign valid_o = (state_q != OCC_EMPTY);
  assign head_o  = entry0_q;

  // The issue logic upstream must never deliver a word into a full buffer.
  captureIntoFull : assert property (@(posedge clk) disable iff (!rst_n)
                                     !(push_i && state_q == OCC_TWO));

endmodule : fifo_rd_adapt_buf

// File: rtl/fifo_rd_stream_adapter.sv
// Turns a synchronous FIFO read port (strobe, one-cycle read latency, empty
// flag) into a valid/ready stream master. Reads are issued only when the word
// they return is guaranteed a slot in the two-entry output buffer, counting the
// word already in flight and any word leaving this cycle.
// Defining FIFO_RD_ADAPT_STATS_EN adds a 16-bit wrapping beat counter output.
module fifo_rd_stream_adapter
  import fifo_adapt_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_ADAPT_STATS_EN
  ,
  output logic [BEAT_CNT_W-1:0] beat_count
`endif
);

  logic             inflight_q, inflight_d;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] committed;

  assign pop = m_valid & m_ready;

  // Words that will occupy the buffer after this edge if no new read is issued.
  // Never exceeds two, so two-bit arithmetic cannot wrap.
  assign committed = occ + OCC_W'(inflight_q) - OCC_W'(pop);

  // Gating with rst_n keeps the strobe low for the whole reset period.
  assign fifo_rd_en = rst_n & en & ~fifo_empty & (committed < OCC_FULL);
  assign fifo_cs    = fifo_rd_en;
  assign inflight_d = fifo_rd_en;

  // Remember that a read was issued so its data is captured next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_rd_adapt_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .valid_o     (m_valid),
    .head_o      (m_data)
  );

`ifdef FIFO_RD_ADAPT_STATS_EN
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;

  assign beat_d     = pop ? beat_q + BEAT_CNT_W'(1) : beat_q;
  assign beat_count = beat_q;

  // Count accepted output beats, wrapping naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end
`else
  // Without statistics there is no beat counter and no extra port.
`endif

endmodule : fifo_rd_stream_adapter
